// File: rtl/fp16_group_acc.sv
// fp16_group_acc
// Sums GROUP_LEN consecutive FP16 products exactly in a wide signed
// fixed-point accumulator (LSB weight 2^-24), then renormalises the group
// total into a single FP16 word for the dequant/output buffer.
// Input and output both use valid/ready handshakes.
module fp16_group_acc #(
    parameter int GROUP_LEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_fp16,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_fp16
);

    localparam int CNT_W = $clog2(GROUP_LEN);
    localparam int ACC_W = 41 + CNT_W;
    localparam int P_W   = $clog2(ACC_W);

    localparam logic [1:0] ST_ACC  = 2'd0;
    localparam logic [1:0] ST_NORM = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUP_LEN - 1);

    localparam logic [P_W-1:0] P_FLUSH = P_W'(9);
    localparam logic [P_W-1:0] P_MANT  = P_W'(10);
    localparam logic [P_W-1:0] P_SAT   = P_W'(40);

    logic [1:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic                    nan;
    logic [15:0]             out_reg;

    logic                    accept;
    logic [4:0]              in_exp;
    logic                    in_special;
    logic [ACC_W-1:0]        term;

    logic                    acc_neg;
    logic [ACC_W-1:0]        mag;
    logic [P_W-1:0]          lead;
    logic [4:0]              norm_exp;
    logic [9:0]              norm_mant;
    logic [15:0]             norm_word;

    assign in_ready   = (state == ST_ACC);
    assign out_valid  = (state == ST_OUT);
    assign out_fp16   = out_reg;
    assign accept     = in_valid & in_ready;
    assign in_exp     = in_fp16[14:10];
    assign in_special = (in_exp == 5'h1F);

    // Convert one FP16 product into an unsigned fixed-point magnitude;
    // subnormals and Inf/NaN contribute nothing to the sum.
    always_comb begin
        term = '0;
        if (in_exp != 5'd0 && !in_special) begin
            term = ACC_W'({1'b1, in_fp16[9:0]}) << (in_exp - 5'd1);
        end
    end

    assign acc_neg = acc[ACC_W-1];
    assign mag     = acc_neg ? $unsigned(-acc) : $unsigned(acc);

    // Locate the leading one of the accumulator magnitude.
    always_comb begin
        lead = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (mag[i]) begin
                lead = P_W'(i);
            end
        end
    end

    assign norm_exp  = 5'(lead - P_FLUSH);
    assign norm_mant = 10'(mag >> (lead - P_MANT));

    // Pick the FP16 result: NaN wins, then exact zero, then underflow
    // flush, then overflow to Inf, otherwise a truncated normal number.
    always_comb begin
        norm_word = 16'h0000;
        if (nan) begin
            norm_word = 16'h7E00;
        end else if (mag == '0) begin
            norm_word = 16'h0000;
        end else if (lead <= P_FLUSH) begin
            norm_word = {acc_neg, 15'h0000};
        end else if (lead >= P_SAT) begin
            norm_word = {acc_neg, 5'h1F, 10'h000};
        end else begin
            norm_word = {acc_neg, norm_exp, norm_mant};
        end
    end

    // Group sequencing: count accepted products, then one normalise cycle,
    // then hold the result until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACC;
            cnt   <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= ST_NORM;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_NORM: begin
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state <= ST_ACC;
                    end
                end
                default: begin
                    state <= ST_ACC;
                end
            endcase
        end
    end

    // Exact signed accumulation plus sticky NaN, cleared once the group
    // result has been handed off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            nan <= 1'b0;
        end else if (accept) begin
            if (in_special) begin
                nan <= 1'b1;
            end else if (in_fp16[15]) begin
                acc <= acc - $signed(term);
            end else begin
                acc <= acc + $signed(term);
            end
        end else if (state == ST_OUT && out_ready) begin
            acc <= '0;
            nan <= 1'b0;
        end
    end

    // Capture the normalised word so it stays stable while out_valid waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg <= 16'h0000;
        end else if (state == ST_NORM) begin
            out_reg <= norm_word;
        end
    end

endmodule

// File: tb/tb_fp16_group_acc.sv
// tb_fp16_group_acc
// Drives a GROUP_LEN=4 and a GROUP_LEN=32 instance with directed and
// randomised groups and compares against a plain-arithmetic group-sum model.
module tb_fp16_group_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_fp16;
    logic        out_ready;
    logic        sel32;

    logic        in_valid4, in_ready4, out_valid4;
    logic [15:0] out_fp16_4;
    logic        in_valid32, in_ready32, out_valid32;
    logic [15:0] out_fp16_32;

    logic        obs_in_ready, obs_out_valid;
    logic [15:0] obs_out_fp16;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] grp[$];

    logic [15:0] dir_in [0:8][0:3] = '{
        '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00},
        '{16'h3C00, 16'hBC00, 16'h4000, 16'h3800},
        '{16'h3C01, 16'hBC00, 16'h0000, 16'h0000},
        '{16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF},
        '{16'hFBFF, 16'hFBFF, 16'hFBFF, 16'hFBFF},
        '{16'h7C00, 16'h3C00, 16'h3C00, 16'h3C00},
        '{16'h0400, 16'h8000, 16'h0000, 16'h0000},
        '{16'h0401, 16'h8400, 16'h0000, 16'h0000},
        '{16'h0001, 16'h0001, 16'h8000, 16'h3C00}
    };
    logic [15:0] dir_exp [0:8] = '{
        16'h4400, 16'h4100, 16'h1400, 16'h7C00, 16'hFC00,
        16'h7E00, 16'h0400, 16'h0000, 16'h3C00
    };

    assign in_valid4     = in_valid & ~sel32;
    assign in_valid32    = in_valid & sel32;
    assign obs_in_ready  = sel32 ? in_ready32  : in_ready4;
    assign obs_out_valid = sel32 ? out_valid32 : out_valid4;
    assign obs_out_fp16  = sel32 ? out_fp16_32 : out_fp16_4;

    always #5 clk = ~clk;

    fp16_group_acc #(.GROUP_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_fp16   (in_fp16),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_fp16  (out_fp16_4)
    );

    fp16_group_acc #(.GROUP_LEN(32)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .in_fp16   (in_fp16),
        .out_valid (out_valid32),
        .out_ready (out_ready),
        .out_fp16  (out_fp16_32)
    );

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: each normal product is an exact integer multiple of 2^-24;
    // add them up, then express the total as a truncated FP16 value.
    function automatic logic [15:0] refSum();
        longint sum = 0;
        longint m;
        int     p;
        bit     nan_seen = 1'b0;
        bit     s;
        foreach (grp[i]) begin
            int     e;
            longint val;
            e = int'(grp[i][14:10]);
            if (e == 31) begin
                nan_seen = 1'b1;
            end else if (e != 0) begin
                val = longint'(1024 + int'(grp[i][9:0])) * (longint'(1) << (e - 1));
                sum = grp[i][15] ? sum - val : sum + val;
            end
        end
        if (nan_seen) return 16'h7E00;
        if (sum == 0) return 16'h0000;
        s = (sum < 0);
        m = s ? -sum : sum;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        if (p <= 9) return {s, 15'h0000};
        if (p >= 40) return {s, 5'h1F, 10'h000};
        return {s, 5'(p - 9), 10'(m >> (p - 10))};
    endfunction

    function automatic logic [15:0] randFp16();
        int         r;
        logic [4:0] e;
        r = $urandom_range(0, 99);
        if (r < 5)       e = 5'd0;
        else if (r < 8)  e = 5'd31;
        else if (r < 15) e = 5'($urandom_range(28, 30));
        else if (r < 22) e = 5'($urandom_range(1, 4));
        else             e = 5'($urandom_range(10, 20));
        return {1'($urandom), e, 10'($urandom)};
    endfunction

    // Feed the current group with random idle gaps, check NORM/OUT timing,
    // stall the consumer, then complete the output handshake.
    task automatic applyStimulus(input string tag, input int gap_pct, input int stall,
                                 input bit junk, input logic [15:0] expv);
        int idx   = 0;
        int guard = 0;
        while (idx < grp.size() && guard < 400) begin
            @(negedge clk);
            guard++;
            checkOutput({tag, "_in_ready"}, 16'(obs_in_ready), 16'd1);
            if (obs_in_ready && $urandom_range(0, 99) >= gap_pct) begin
                in_valid = 1'b1;
                in_fp16  = grp[idx];
                idx++;
            end else begin
                in_valid = 1'b0;
                in_fp16  = 16'($urandom);
            end
        end
        if (idx < grp.size()) begin
            checkOutput({tag, "_accept_budget"}, 16'(idx), 16'(grp.size()));
        end
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput({tag, "_norm_valid"}, 16'(obs_out_valid), 16'd0);
        checkOutput({tag, "_norm_ready"}, 16'(obs_in_ready), 16'd0);
        @(negedge clk);
        checkOutput({tag, "_out_valid"}, 16'(obs_out_valid), 16'd1);
        checkOutput({tag, "_out_ready"}, 16'(obs_in_ready), 16'd0);
        checkOutput({tag, "_sum"}, obs_out_fp16, expv);
        for (int c = 0; c < stall; c++) begin
            in_valid  = junk;
            in_fp16   = 16'($urandom);
            out_ready = 1'b0;
            @(negedge clk);
            checkOutput({tag, "_stall_valid"}, 16'(obs_out_valid), 16'd1);
            checkOutput({tag, "_stall_sum"}, obs_out_fp16, expv);
            checkOutput({tag, "_stall_ready"}, 16'(obs_in_ready), 16'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_done_valid"}, 16'(obs_out_valid), 16'd0);
        checkOutput({tag, "_done_ready"}, 16'(obs_in_ready), 16'd1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] a;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_fp16   = 16'h0000;
        out_ready = 1'b0;
        sel32     = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", 16'(obs_in_ready), 16'd1);
        checkOutput("reset_out_valid", 16'(obs_out_valid), 16'd0);
        checkOutput("reset_out_fp16", obs_out_fp16, 16'h0000);
        rst = 1'b0;

        for (int d = 0; d < 9; d++) begin
            grp.delete();
            for (int j = 0; j < 4; j++) grp.push_back(dir_in[d][j]);
            applyStimulus($sformatf("dir%0d", d), 0, (d == 0) ? 5 : 0, 1'b1, dir_exp[d]);
        end

        grp = {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
        applyStimulus("gaps", 50, 2, 1'b0, 16'h4400);

        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_fp16  = 16'h3C00;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #2;
        checkOutput("midrst_in_ready", 16'(obs_in_ready), 16'd1);
        checkOutput("midrst_out_valid", 16'(obs_out_valid), 16'd0);
        checkOutput("midrst_out_fp16", obs_out_fp16, 16'h0000);
        #1 rst = 1'b0;
        grp = {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
        applyStimulus("after_rst", 0, 0, 1'b0, 16'h4400);

        for (int g = 0; g < 40; g++) begin
            grp.delete();
            if ($urandom_range(0, 3) == 0) begin
                a = randFp16();
                grp.push_back(a);
                grp.push_back(a ^ 16'h8000 ^ 16'($urandom_range(0, 3)));
                grp.push_back(randFp16());
                grp.push_back(16'h0000);
            end else begin
                for (int j = 0; j < 4; j++) grp.push_back(randFp16());
            end
            applyStimulus("rnd", $urandom_range(0, 40), $urandom_range(0, 3), 1'($urandom), refSum());
        end

        @(negedge clk);
        sel32 = 1'b1;
        grp.delete();
        for (int j = 0; j < 32; j++) grp.push_back(16'h3C00);
        applyStimulus("g32_ones", 0, 1, 1'b1, 16'h5000);
        for (int g = 0; g < 3; g++) begin
            grp.delete();
            for (int j = 0; j < 32; j++) grp.push_back(randFp16());
            applyStimulus("g32_rnd", $urandom_range(0, 30), $urandom_range(0, 2), 1'($urandom), refSum());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
